// File: rtl/ahbl_master_bridge_if.sv
// Command/data port plus AHB-Lite bus of the master bridge; 'master' is the bridge side,
// 'slave' is the side that issues commands and answers the bus.
interface ahbl_master_bridge_if #(
    parameter int AHB_DWIDTH = 32,
    parameter int AHB_AWIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [AHB_AWIDTH-1:0] cmd_addr;
    logic [2:0]            cmd_size;
    logic [4:0]            cmd_len;
    logic [AHB_DWIDTH-1:0] wdata;
    logic                  wd_pop;
    logic [AHB_DWIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  done;
    logic                  err;
    logic [AHB_AWIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [AHB_DWIDTH-1:0] HWDATA;
    logic [AHB_DWIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_len, wdata,
        input  HRDATA, HREADY, HRESP,
        output cmd_ready, wd_pop, rd_data, rd_valid, done, err,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_len, wdata,
        output HRDATA, HREADY, HRESP,
        input  cmd_ready, wd_pop, rd_data, rd_valid, done, err,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );
endinterface

// File: rtl/ahbl_master_bridge.sv
// AHB-Lite master: turns local read/write commands into pipelined SINGLE/INCRx transfers,
// with wait-state support and two-cycle ERROR response handling.
module ahbl_master_bridge #(
    parameter int AHB_DWIDTH = 32,
    parameter int AHB_AWIDTH = 32
) (
    input  logic                 HCLK,
    input  logic                 aresetn,
    ahbl_master_bridge_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_BURST, S_LAST} state_t;
    localparam logic [1:0] TR_IDLE = 2'b00, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11;

    state_t                state;
    logic [4:0]            len_q, issued, completed;
    logic [4:0]            len_eff;
    logic [11:0]           cmd_end;
    logic [2:0]            burst_enc;
    logic                  illegal, dph;
    logic [AHB_AWIDTH-1:0] step;

    assign len_eff = (bus.cmd_len == 5'd0) ? 5'd1 : bus.cmd_len;
    // One past the last byte, measured from the start of the 1 KB page holding cmd_addr.
    assign cmd_end = {2'b00, bus.cmd_addr[9:0]} + (12'(len_eff) << bus.cmd_size[1:0]);
    assign step    = AHB_AWIDTH'(1) << bus.HSIZE[1:0];
    assign dph     = (state == S_BURST) || (state == S_LAST);

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.wd_pop    = bus.HTRANS[1] & bus.HREADY & bus.HWRITE;

    always_comb begin
        illegal = 1'b0;
        if (bus.cmd_size > 3'd2)                               illegal = 1'b1;
        else if (bus.cmd_size == 3'd1 && bus.cmd_addr[0])      illegal = 1'b1;
        else if (bus.cmd_size == 3'd2 && bus.cmd_addr[1:0] != 2'b00) illegal = 1'b1;
        else if (cmd_end > 12'd1024)                           illegal = 1'b1;
    end

    always_comb begin
        case (len_eff)
            5'd1:    burst_enc = 3'b000;
            5'd4:    burst_enc = 3'b011;
            5'd8:    burst_enc = 3'b101;
            5'd16:   burst_enc = 3'b111;
            default: burst_enc = 3'b001;
        endcase
    end

    always_ff @(posedge HCLK or negedge aresetn) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            len_q      <= 5'd0;
            issued     <= 5'd0;
            completed  <= 5'd0;
            bus.HADDR  <= '0;
            bus.HTRANS <= TR_IDLE;
            bus.HWRITE <= 1'b0;
            bus.HSIZE  <= 3'd0;
            bus.HBURST <= 3'd0;
            bus.HWDATA <= {AHB_DWIDTH{1'b0}};
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            bus.rd_valid <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            if (bus.wd_pop) bus.HWDATA <= bus.wdata;
            // An errored read beat is never returned.
            if (dph && bus.HREADY && !bus.HWRITE && !bus.HRESP) begin
                bus.rd_data  <= bus.HRDATA;
                bus.rd_valid <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (illegal) begin
                            bus.done <= 1'b1;
                            bus.err  <= 1'b1;
                        end else begin
                            state      <= S_ADDR;
                            bus.HTRANS <= TR_NONSEQ;
                            bus.HADDR  <= bus.cmd_addr;
                            bus.HWRITE <= bus.cmd_write;
                            bus.HSIZE  <= bus.cmd_size;
                            bus.HBURST <= burst_enc;
                            len_q      <= len_eff;
                            issued     <= 5'd0;
                            completed  <= 5'd0;
                        end
                    end
                end
                S_ADDR: begin
                    if (bus.HREADY) begin
                        issued <= 5'd1;
                        if (len_q == 5'd1) begin
                            state      <= S_LAST;
                            bus.HTRANS <= TR_IDLE;
                        end else begin
                            state      <= S_BURST;
                            bus.HTRANS <= TR_SEQ;
                            bus.HADDR  <= bus.HADDR + step;
                        end
                    end
                end
                S_BURST: begin
                    if (bus.HRESP && !bus.HREADY) begin
                        // First ERROR cycle: drop the pending address phase, drain the errored one.
                        state      <= S_LAST;
                        bus.HTRANS <= TR_IDLE;
                    end else if (bus.HREADY) begin
                        issued    <= issued + 5'd1;
                        completed <= completed + 5'd1;
                        if (issued + 5'd1 == len_q) begin
                            state      <= S_LAST;
                            bus.HTRANS <= TR_IDLE;
                        end else begin
                            bus.HADDR <= bus.HADDR + step;
                        end
                    end
                end
                S_LAST: begin
                    if (bus.HREADY) begin
                        completed <= completed + 5'd1;
                        state     <= S_IDLE;
                        bus.done  <= 1'b1;
                        bus.err   <= bus.HRESP | (completed + 5'd1 != len_q);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahbl_master_bridge.sv
// Bench for ahbl_master_bridge: reactive AHB slave with wait/error injection and a
// per-command transaction model of address phases, write data, read beats and completion.
module tb_ahbl_master_bridge;
    logic HCLK = 1'b0;
    logic aresetn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahbl_master_bridge_if #(.AHB_DWIDTH(32), .AHB_AWIDTH(32)) bus ();
    ahbl_master_bridge #(.AHB_DWIDTH(32), .AHB_AWIDTH(32)) dut (
        .HCLK(HCLK), .aresetn(aresetn), .bus(bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [2:0]  size;
        logic        wr;
    } aph_t;

    int errors = 0, checks = 0, cyc = 0;
    aph_t        exp_aph[$];
    logic [31:0] exp_rd[$], exp_wd[$], wsrc[$];
    logic [31:0] obs_addr[$];
    logic [1:0]  obs_trans[$];
    logic [2:0]  obs_burst;
    logic [31:0] rd_seed = 32'h0, last_rd = 32'h0;
    logic        exp_err = 1'b0, last_err = 1'b0;
    int exp_pops = 0, pops = 0, done_cnt = 0, done_cyc = 0, first_aph_cyc = 0;
    int aph_seen = 0, rd_cnt = 0, last_rd_cyc = 0, err_beat = 0;
    int wait_tab[1:16];
    // slave data-phase state and previous-cycle bus snapshot
    logic        s_dph = 1'b0, s_wr = 1'b0;
    logic [31:0] s_addr = 32'h0;
    int          s_beat = 0, s_waits = 0, s_estage = 0;
    logic [1:0]  p_trans = 2'b00;
    logic [31:0] p_addr = 32'h0;
    logic        p_wr = 1'b0, p_ready = 1'b0, p_resp = 1'b0, p_pop = 1'b0;

    always @(posedge HCLK) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [2:0] burst_of(input int n);
        case (n)
            1:       return 3'b000;
            4:       return 3'b011;
            8:       return 3'b101;
            16:      return 3'b111;
            default: return 3'b001;
        endcase
    endfunction

    task automatic slave_step();
        if (!aresetn) begin
            s_dph = 1'b0; s_estage = 0;
            bus.HREADY = 1'b1; bus.HRESP = 1'b0;
            p_trans = 2'b00; p_ready = 1'b0; p_resp = 1'b0; p_pop = 1'b0;
            return;
        end
        if (p_pop) begin
            if (wsrc.size() > 0) void'(wsrc.pop_front());
            bus.wdata = (wsrc.size() > 0) ? wsrc[0] : $urandom;
        end
        if (p_ready) begin
            s_dph = p_trans[1];
            if (s_dph) begin
                s_addr = p_addr; s_wr = p_wr; s_beat++;
                s_waits = (s_beat <= 16) ? wait_tab[s_beat] : 0;
                s_estage = 0;
            end
        end
        if (s_dph && s_waits > 0) begin
            bus.HREADY = 1'b0; bus.HRESP = 1'b0; s_waits--;
        end else if (s_dph && s_beat == err_beat && s_estage == 0) begin
            bus.HREADY = 1'b0; bus.HRESP = 1'b1; s_estage = 1;
        end else if (s_dph && s_beat == err_beat && s_estage == 1) begin
            bus.HREADY = 1'b1; bus.HRESP = 1'b1; s_estage = 2;
        end else begin
            bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        end
        bus.HRDATA = (s_dph && !s_wr) ? (rd_seed ^ s_addr) : $urandom;
    endtask

    task automatic check_step();
        aph_t e;
        logic [31:0] w;
        if (!aresetn) return;
        if (p_resp && !p_ready) chk("htrans_after_err1", bus.HTRANS, 2'b00);
        if (bus.HTRANS != 2'b00 && bus.HREADY) begin
            aph_seen++;
            if (aph_seen == 1) first_aph_cyc = cyc;
            obs_addr.push_back(bus.HADDR);
            obs_trans.push_back(bus.HTRANS);
            obs_burst = bus.HBURST;
            if (exp_aph.size() == 0) fail_now("unexpected_addr_phase");
            else begin
                e = exp_aph.pop_front();
                chk("haddr", bus.HADDR, e.addr);
                chk("htrans", bus.HTRANS, e.trans);
                chk("hburst", bus.HBURST, e.burst);
                chk("hsize", bus.HSIZE, e.size);
                chk("hwrite", bus.HWRITE, e.wr);
            end
        end
        if (bus.wd_pop) pops++;
        if (s_dph && s_wr && bus.HREADY) begin
            if (exp_wd.size() == 0) fail_now("unexpected_write_data_phase");
            else begin
                w = exp_wd.pop_front();
                chk("hwdata", bus.HWDATA, w);
            end
        end
        if (bus.rd_valid) begin
            rd_cnt++; last_rd_cyc = cyc; last_rd = bus.rd_data;
            if (exp_rd.size() == 0) fail_now("unexpected_rd_valid");
            else begin
                w = exp_rd.pop_front();
                chk("rd_data", bus.rd_data, w);
            end
        end
        if (bus.done) begin
            done_cnt++; done_cyc = cyc; last_err = bus.err;
            chk("done_err", bus.err, exp_err);
            chk("done_leftover_beats", exp_aph.size() + exp_rd.size() + exp_wd.size(), 0);
            chk("done_wd_pops", pops, exp_pops);
        end
        p_trans = bus.HTRANS; p_addr = bus.HADDR; p_wr = bus.HWRITE;
        p_ready = bus.HREADY; p_resp = bus.HRESP; p_pop = bus.wd_pop;
    endtask

    initial forever begin
        @(negedge HCLK);
        slave_step();
        #1;
        check_step();
    end

    // Builds the expected transaction from the command rules, issues it, optionally waits for done.
    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [4:0] len, input int eb, input bit seq_data,
                           input bit wait_done, output int t_acc);
        int L, bytes, n_acc, n_rd, d0, k;
        bit ill, erred;
        aph_t a;
        logic [31:0] dv;
        L = (len == 0) ? 1 : int'(len);
        bytes = 1 << size;
        ill = (size > 2) || ((addr % bytes) != 0) || ((addr % 1024) + L * bytes > 1024);
        erred = !ill && eb > 0 && eb <= L;
        n_acc = ill ? 0 : (erred ? eb : L);
        n_rd = (ill || wr) ? 0 : (erred ? eb - 1 : L);
        err_beat = erred ? eb : 0;
        exp_err = ill || erred;
        exp_pops = wr ? n_acc : 0;
        for (int i = 0; i < n_acc; i++) begin
            a.addr = addr + i * bytes;
            a.trans = (i == 0) ? 2'b10 : 2'b11;
            a.burst = burst_of(L);
            a.size = size;
            a.wr = wr;
            exp_aph.push_back(a);
            if (wr) begin
                dv = seq_data ? 32'(i + 1) : $urandom;
                exp_wd.push_back(dv);
                wsrc.push_back(dv);
            end
        end
        for (int i = 0; i < n_rd; i++) exp_rd.push_back(rd_seed ^ (addr + i * bytes));
        @(negedge HCLK);
        s_beat = 0; pops = 0; aph_seen = 0; rd_cnt = 0;
        obs_addr.delete(); obs_trans.delete(); obs_burst = 3'b110;
        d0 = done_cnt;
        bus.wdata = (wsrc.size() > 0) ? wsrc[0] : 32'h0;
        bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_size = size; bus.cmd_len = len;
        bus.cmd_valid = 1'b1;
        t_acc = cyc;
        chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
        @(posedge HCLK);
        #1 bus.cmd_valid = 1'b0;
        if (wait_done) begin
            k = 0;
            while (done_cnt == d0 && k < 400) begin
                @(posedge HCLK);
                k++;
            end
            if (done_cnt == d0) fail_now("done_timeout");
            @(posedge HCLK);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ahb_ctrl"}, {bus.HADDR, bus.HTRANS, bus.HWRITE, bus.HSIZE, bus.HBURST}, 64'h0);
        chk({tag, "_hwdata"}, bus.HWDATA, 32'h0);
        chk({tag, "_rd_data"}, bus.rd_data, 32'h0);
        chk({tag, "_strobes"}, {bus.wd_pop, bus.rd_valid, bus.done, bus.err}, 4'h0);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, d0, k, L, sz, eb;
        logic [31:0] ad;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_size = 3'd0; bus.cmd_len = 5'd0; bus.wdata = '0;
        bus.HRDATA = '0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        for (int i = 1; i <= 16; i++) wait_tab[i] = 0;
        #3 chk_reset_vals("reset");
        repeat (2) @(negedge HCLK);
        aresetn = 1'b1;
        repeat (2) @(posedge HCLK);

        // single zero-wait read
        rd_seed = 32'hA5A5_0101;
        run_cmd(1'b0, 32'h100, 3'd2, 5'd1, 0, 0, 1, t);
        chk("single_rd_data", last_rd, 32'hA5A5_0001);
        chk("single_nonseq_cycle", first_aph_cyc - t, 1);
        chk("single_done_cycle", done_cyc - t, 3);
        chk("single_rd_with_done", last_rd_cyc, done_cyc);
        chk("single_hburst", obs_burst, 3'b000);
        chk("single_err", last_err, 1'b0);

        // INCR4 write with two wait states on beat 2
        wait_tab[2] = 2;
        d0 = done_cnt;
        run_cmd(1'b1, 32'h40, 3'd2, 5'd4, 0, 1, 1, t);
        wait_tab[2] = 0;
        repeat (3) @(posedge HCLK);
        chk("incr4_addrs", {obs_addr[0][7:0], obs_addr[1][7:0], obs_addr[2][7:0], obs_addr[3][7:0]},
            32'h40444_84C);
        chk("incr4_trans", {obs_trans[0], obs_trans[1], obs_trans[2], obs_trans[3]}, 8'b10_11_11_11);
        chk("incr4_pops", pops, 4);
        chk("incr4_done_once", done_cnt - d0, 1);
        chk("incr4_hburst", obs_burst, 3'b011);

        // len=5 halfword read from 0x2
        run_cmd(1'b0, 32'h2, 3'd1, 5'd5, 0, 0, 1, t);
        chk("len5_hburst", obs_burst, 3'b001);
        chk("len5_last_addr", obs_addr[4], 32'hA);
        chk("len5_rd_count", rd_cnt, 5);
        chk("len5_done_cycle", done_cyc - t, 7);

        // ERROR on beat 2 of an INCR8 read
        run_cmd(1'b0, 32'h200, 3'd2, 5'd8, 2, 0, 1, t);
        chk("err_rd_count", rd_cnt, 1);
        chk("err_flag", last_err, 1'b1);
        chk("err_addr_phases", aph_seen, 2);

        // illegal commands: 1 KB crossing, misaligned word
        run_cmd(1'b0, 32'h3FC, 3'd2, 5'd2, 0, 0, 1, t);
        chk("ill_cross_done_cycle", done_cyc - t, 1);
        chk("ill_cross_no_bus", aph_seen, 0);
        chk("ill_cross_err", last_err, 1'b1);
        run_cmd(1'b1, 32'h1, 3'd2, 5'd1, 0, 0, 1, t);
        chk("ill_align_done_cycle", done_cyc - t, 1);
        chk("ill_align_no_bus", aph_seen + pops, 0);
        chk("ill_align_err", last_err, 1'b1);

        // reset during beat 3 of an INCR16 read, then a single write
        run_cmd(1'b0, 32'h0, 3'd2, 5'd16, 0, 0, 0, t);
        k = 0;
        while (aph_seen < 3 && k < 50) begin
            @(negedge HCLK);
            #2 k++;
        end
        if (aph_seen < 3) fail_now("incr16_beat3_timeout");
        d0 = done_cnt;
        aresetn = 1'b0;
        #1 chk_reset_vals("midreset");
        exp_aph.delete(); exp_rd.delete(); exp_wd.delete(); wsrc.delete(); err_beat = 0;
        repeat (2) @(negedge HCLK);
        aresetn = 1'b1;
        repeat (4) @(posedge HCLK);
        chk("midreset_no_done", done_cnt - d0, 0);
        run_cmd(1'b1, 32'h10, 3'd2, 5'd1, 0, 1, 1, t);
        chk("post_reset_done_cycle", done_cyc - t, 3);
        chk("post_reset_err", last_err, 1'b0);
        chk("post_reset_pops", pops, 1);

        // randomized commands with wait states, errors and illegal requests
        for (int n = 0; n < 60; n++) begin
            sz = ($urandom % 10 == 0) ? 3 : int'($urandom % 3);
            L = int'($urandom % 17);
            ad = ($urandom % 2048) & ~((32'd1 << sz) - 1);
            if ($urandom % 10 == 0) ad = ad + 1;
            eb = ($urandom % 6 == 0) ? 1 + int'($urandom % ((L == 0) ? 1 : L)) : 0;
            for (int i = 1; i <= 16; i++) wait_tab[i] = int'($urandom % 3);
            rd_seed = $urandom;
            run_cmd(1'($urandom % 2), ad, 3'(sz), 5'(L), eb, 0, 1, t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ahbl_master_bridge.md
# ahbl_master_bridge

AHB-Lite master (initiator) that converts a simple local command port into AHB-Lite single and burst transfers, targeting the LSRAM AHB slave and other fabric AHB slaves. It serves DMA/sequencer logic that needs to read or write SRAM over the AHB-Lite fabric. Address and data phases are pipelined, wait states and ERROR responses are handled, and read data is returned beat by beat.

## Interface
- AHB_DWIDTH, 32: data width; only 32 is supported.
- AHB_AWIDTH, 32: address width.
- HCLK  in  1  bus clock; all logic is rising-edge.
- aresetn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; the command is accepted when cmd_valid&cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AHB_AWIDTH  start byte address.
- cmd_size  in  3  HSIZE encoding, 0..2.
- cmd_len  in  5  beat count, 1..16; 0 is treated as 1.
- wdata  in  32  write beat; must be valid whenever wd_pop is high (FWFT source).
- wd_pop  out  1  1-cycle pulse; wdata is consumed that cycle.
- rd_data  out  32  read beat.
- rd_valid  out  1  1-cycle strobe qualifying rd_data.
- done  out  1  1-cycle pulse at command end.
- err  out  1  valid with done; 1 = ERROR response or illegal command.
- HADDR  out  AHB_AWIDTH; HTRANS  out  2; HWRITE  out  1; HSIZE  out  3; HBURST  out  3; HWDATA  out  32.
- HRDATA  in  32; HREADY  in  1; HRESP  in  1.

## Operation
- State machine with four states:
  - IDLE: cmd_ready=1.
  - ADDR: first beat in address phase, NONSEQ.
  - BURST: address phase of SEQ beats overlapping prior data phases.
  - LAST: final data phase only, HTRANS=IDLE.
  - Transitions: IDLE->ADDR on accept; ADDR->BURST (len>1) or LAST (len=1) on HREADY; BURST->LAST when the last address phase is accepted; LAST->IDLE on HREADY.
- Illegal command: cmd_size>2, address misaligned to 1<<cmd_size, or start+len*(1<<size) crossing a 1 KB boundary. Response: no bus activity, done=1 and err=1 the cycle after accept, back to IDLE.
- HBURST mapping:
  - len 1 -> SINGLE (000)
  - len 4 -> INCR4 (011)
  - len 8 -> INCR8 (101)
  - len 16 -> INCR16 (111)
  - any other len -> INCR (001)
  - HBURST, HSIZE and HWRITE are constant for the whole command.
- Addressing: HADDR advances by 1<<size per accepted address phase, using a 5-bit issued-beat counter and a 5-bit completed-beat counter. The command completes when completed == len.
- Write data: wd_pop pulses in the cycle an address phase is accepted (HTRANS!=IDLE & HREADY). HWDATA is registered from wdata in that cycle and held until its data phase completes.
- Read data: HRDATA is captured on HREADY=1 in a read data phase; rd_valid is asserted the following cycle.
- ERROR handling:
  - HRESP=1 & HREADY=0 (first error cycle): next cycle HTRANS=IDLE, the pending transfer is cancelled, and no further beats or wd_pop are issued.
  - HRESP=1 & HREADY=1 (second error cycle): ends the command; the errored read beat gives no rd_valid; done=1 and err=1 next cycle.
- BUSY transfers are never issued.

## Timing
- Reset values: HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0, wd_pop=0, rd_valid=0, rd_data=0, done=0, err=0, state IDLE (cmd_ready=1).
- All AHB outputs are registered.
- Zero-wait single read:
  - accept T
  - NONSEQ at T+1
  - data phase T+2
  - rd_valid and done at T+3
  - next accept no earlier than T+3
- N-beat zero-wait burst: beat k address phase at T+1+k; done at T+N+2.
- Wait states: HREADY=0 holds HADDR/HTRANS/HWDATA unchanged and freezes both counters.
- Reset mid-command: outputs take reset values asynchronously; no done pulse; the command is lost.

## Test plan
- Single read, len=1, addr 0x100, size 2, zero wait: HTRANS=10 at T+1, HBURST=000; HRDATA=0xA5A5_0001 -> rd_data=0xA5A5_0001 with rd_valid and done at T+3, err=0.
- INCR4 write, addr 0x40, data 1..4, HREADY low 2 cycles on beat 2: HADDR 0x40,0x44,0x48,0x4C with HTRANS 10,11,11,11; HWDATA order 1..4; exactly 4 wd_pop pulses; done once.
- len=5 read, size 1, addr 0x2: HBURST=001, HADDR steps by 2 up to 0xA, 5 rd_valid pulses.
- ERROR on beat 2 of INCR8 read: HTRANS=00 the cycle after the first error cycle; only beat 1 gives rd_valid; done=1, err=1.
- Illegal commands: addr 0x3FC, len=2, size 2 (crosses 1 KB), and addr 0x1 with size 2 -> no HTRANS activity, done=1, err=1 at T+1.
- aresetn asserted during beat 3 of INCR16: all outputs at reset values immediately; a new single write after reset completes normally.
